// File: rtl/paicore_pkg.sv
// Shared types and helpers for the PAICORE send-path schedulers.
package paicore_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN       = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_e;

  localparam int CNT_WD_DEF = 32;
  // Split arithmetic runs at this width so the +1 of the ceil half never wraps.
  localparam int SPLIT_WD   = 64;

  // Half of a beat total: take_odd=1 gives ceil(total/2), take_odd=0 gives floor(total/2).
  function automatic logic [SPLIT_WD-1:0] split_half(input logic [SPLIT_WD-1:0] total,
                                                     input logic                take_odd);
    logic [SPLIT_WD:0] w_sum;
    w_sum = {1'b0, total} + {{SPLIT_WD{1'b0}}, take_odd};
    return w_sum[SPLIT_WD:1];
  endfunction

endpackage

// File: rtl/paicore_done_collect.sv
// Sticky per-channel done flags with zero-length pre-set and all-done detect.
module paicore_done_collect (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_cap_en,
  input  logic i_preset,
  input  logic i_zero0,
  input  logic i_zero1,
  input  logic i_done0,
  input  logic i_done1,
  output logic o_f0,
  output logic o_f1,
  output logic o_all_done
);

  logic r_f0;
  logic r_f1;
  logic w_set0;
  logic w_set1;

  assign w_set0 = (i_cap_en & i_done0) | (i_preset & i_zero0);
  assign w_set1 = (i_cap_en & i_done1) | (i_preset & i_zero1);

  // Flags only ever set until the next accepted start clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f0 <= 1'b0;
      r_f1 <= 1'b0;
    end else if (i_clr) begin
      r_f0 <= 1'b0;
      r_f1 <= 1'b0;
    end else begin
      r_f0 <= r_f0 | w_set0;
      r_f1 <= r_f1 | w_set1;
    end
  end

  // Bypass the incoming pulses so completion is seen in the cycle a flag sets.
  assign o_all_done = (r_f0 | w_set0) & (r_f1 | w_set1);
  assign o_f0       = r_f0;
  assign o_f1       = r_f1;

endmodule

// File: rtl/paicore_send_sched.sv
// Dual-channel send transaction controller: length split, source gating, done collection.
// Optional watchdog enabled by defining PAICORE_SEND_SCHED_TIMEOUT_EN.
module paicore_send_sched
  import paicore_pkg::*;
#(
  parameter int               CNT_WD = CNT_WD_DEF,
  parameter int               TO_WD  = 24,
  parameter logic [TO_WD-1:0] TO_CYC = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_WD-1:0] cfg_send_len,
  input  logic              cfg_dual,
  output logic              fork_enable,
  output logic              src_gate,
  input  logic              src_hsk,
  input  logic              c0_hsk,
  input  logic              c1_hsk,
  input  logic              c0_done,
  input  logic              c1_done,
  output logic [CNT_WD-1:0] len_c0,
  output logic [CNT_WD-1:0] len_c1,
  output logic [CNT_WD-1:0] cnt_c0,
  output logic [CNT_WD-1:0] cnt_c1,
  output logic              busy,
  output logic              tx_done,
  output logic              err_len,
  output logic              timeout
);

  localparam logic [CNT_WD-1:0] ONE   = {{(CNT_WD-1){1'b0}}, 1'b1};
  localparam logic [CNT_WD:0]   ONE_X = {{CNT_WD{1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_base;
  state_e            w_state_nxt;
  logic [CNT_WD-1:0] r_len_total;
  logic [CNT_WD-1:0] r_len_c0;
  logic [CNT_WD-1:0] r_len_c1;
  logic [CNT_WD-1:0] r_cnt_c0;
  logic [CNT_WD-1:0] r_cnt_c1;
  logic [CNT_WD-1:0] r_src_cnt;
  logic [CNT_WD-1:0] w_len_c0;
  logic [CNT_WD-1:0] w_len_c1;
  logic              r_dual;
  logic              r_fork_en;
  logic              r_err_len;
  logic              r_tx_done;
  logic              w_start_acc;
  logic              w_cnt_state;
  logic              w_src_last;
  logic              w_all_done;
  logic              w_wd_fire;
  logic              w_f0;
  logic              w_f1;

  assign w_start_acc = (r_state == IDLE) & start;
  assign w_cnt_state = (r_state == LOAD) | (r_state == RUN) | (r_state == WAIT_DONE);
  assign w_src_last  = (({1'b0, r_src_cnt} + ONE_X) == {1'b0, r_len_total});

  // Per-channel lengths from the latched total; C0 takes the odd beat.
  always_comb begin
    w_len_c0 = {CNT_WD{1'b0}};
    w_len_c1 = {CNT_WD{1'b0}};
    if (r_dual) begin
      w_len_c0 = CNT_WD'(split_half(SPLIT_WD'(r_len_total), 1'b1));
      w_len_c1 = CNT_WD'(split_half(SPLIT_WD'(r_len_total), 1'b0));
    end else begin
      w_len_c0 = r_len_total;
      w_len_c1 = {CNT_WD{1'b0}};
    end
  end

  paicore_done_collect u_done_collect (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start_acc),
    .i_cap_en   (r_state != IDLE),
    .i_preset   (r_state == LOAD),
    .i_zero0    (w_len_c0 == {CNT_WD{1'b0}}),
    .i_zero1    (w_len_c1 == {CNT_WD{1'b0}}),
    .i_done0    (c0_done),
    .i_done1    (c1_done),
    .o_f0       (w_f0),
    .o_f1       (w_f1),
    .o_all_done (w_all_done)
  );

  // Next-state decode; a watchdog expiry overrides everything.
  always_comb begin
    w_state_base = r_state;
    case (r_state)
      IDLE:      w_state_base = start ? LOAD : IDLE;
      LOAD:      w_state_base = (r_len_total == {CNT_WD{1'b0}}) ? DONE : RUN;
      RUN:       w_state_base = (src_hsk && w_src_last) ? WAIT_DONE : RUN;
      WAIT_DONE: w_state_base = w_all_done ? DONE : WAIT_DONE;
      DONE:      w_state_base = IDLE;
      default:   w_state_base = IDLE;
    endcase
    w_state_nxt = w_wd_fire ? DONE : w_state_base;
  end

  // State register; tx_done is the registered image of DONE, one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_done <= (r_state == DONE);
    end
  end

  // Transaction configuration; lengths and fork mode hold until the next LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_total <= {CNT_WD{1'b0}};
      r_dual      <= 1'b0;
      r_len_c0    <= {CNT_WD{1'b0}};
      r_len_c1    <= {CNT_WD{1'b0}};
      r_fork_en   <= 1'b0;
    end else if (w_start_acc) begin
      r_len_total <= cfg_send_len;
      r_dual      <= cfg_dual;
    end else if (r_state == LOAD) begin
      r_len_c0    <= w_len_c0;
      r_len_c1    <= w_len_c1;
      r_fork_en   <= r_dual;
    end
  end

  // Source and per-channel beat counters with overrun detection.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_src_cnt <= {CNT_WD{1'b0}};
      r_cnt_c0  <= {CNT_WD{1'b0}};
      r_cnt_c1  <= {CNT_WD{1'b0}};
      r_err_len <= 1'b0;
    end else begin
      if ((r_state == RUN) && src_hsk) begin
        r_src_cnt <= r_src_cnt + ONE;
      end
      if (w_cnt_state && c0_hsk) begin
        if (r_cnt_c0 != {CNT_WD{1'b1}}) r_cnt_c0 <= r_cnt_c0 + ONE;
        if (({1'b0, r_cnt_c0} + ONE_X) > {1'b0, w_len_c0}) r_err_len <= 1'b1;
      end
      if (w_cnt_state && c1_hsk) begin
        if (r_cnt_c1 != {CNT_WD{1'b1}}) r_cnt_c1 <= r_cnt_c1 + ONE;
        if (({1'b0, r_cnt_c1} + ONE_X) > {1'b0, w_len_c1}) r_err_len <= 1'b1;
      end
    end
  end

`ifdef PAICORE_SEND_SCHED_TIMEOUT_EN
  logic [TO_WD-1:0] r_wd;
  logic             r_timeout;
  logic             w_wd_state;
  logic             w_activity;

  assign w_wd_state = (r_state == RUN) | (r_state == WAIT_DONE);
  assign w_activity = src_hsk | c0_hsk | c1_hsk | c0_done | c1_done;
  assign w_wd_fire  = w_wd_state & ~w_activity & (r_wd == (TO_CYC - TO_WD'(1)));

  // Idle-cycle watchdog; restarts on any channel activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= {TO_WD{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      if (!w_wd_state || w_activity || w_wd_fire) r_wd <= {TO_WD{1'b0}};
      else                                        r_wd <= r_wd + TO_WD'(1);
      if (w_start_acc)    r_timeout <= 1'b0;
      else if (w_wd_fire) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = ^TO_CYC;
  assign w_wd_fire   = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign fork_enable = r_fork_en;
  assign src_gate    = (r_state == RUN);
  assign busy        = (r_state != IDLE);
  assign tx_done     = r_tx_done;
  assign err_len     = r_err_len;
  assign len_c0      = r_len_c0;
  assign len_c1      = r_len_c1;
  assign cnt_c0      = r_cnt_c0;
  assign cnt_c1      = r_cnt_c1;

endmodule

// File: tb/tb_paicore_send_sched.sv
// Directed self-checking bench for paicore_send_sched.
module tb_paicore_send_sched;

  logic        clk = 1'b0;
  logic        rst, start, cfg_dual, src_hsk, c0_hsk, c1_hsk, c0_done, c1_done;
  logic [31:0] cfg_send_len;
  logic        fork_enable, src_gate, busy, tx_done, err_len, timeout;
  logic [31:0] len_c0, len_c1, cnt_c0, cnt_c1;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          adm;
  int          pulses;

  paicore_send_sched #(.CNT_WD(32), .TO_WD(24), .TO_CYC(24'd16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_send_len(cfg_send_len), .cfg_dual(cfg_dual),
    .fork_enable(fork_enable), .src_gate(src_gate), .src_hsk(src_hsk),
    .c0_hsk(c0_hsk), .c1_hsk(c1_hsk), .c0_done(c0_done), .c1_done(c1_done),
    .len_c0(len_c0), .len_c1(len_c1), .cnt_c0(cnt_c0), .cnt_c1(cnt_c1),
    .busy(busy), .tx_done(tx_done), .err_len(err_len), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start pulse lasts one cycle; returns in the LOAD cycle (T+1).
  task automatic start_tx(input logic [31:0] len, input logic dual);
    cfg_send_len = len;
    cfg_dual     = dual;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Ideal senders: a beat every cycle while gated open, alternating C0/C1 in dual mode.
  task automatic run_beats(input logic dual, output int n);
    n = 0;
    for (int k = 0; k < 40 && src_gate; k++) begin
      src_hsk = 1'b1;
      c0_hsk  = !dual || (n % 2 == 0);
      c1_hsk  = dual && (n % 2 == 1);
      n++;
      tick();
    end
    src_hsk = 1'b0;
    c0_hsk  = 1'b0;
    c1_hsk  = 1'b0;
  endtask

  task automatic pulse_done(input logic d0, input logic d1);
    c0_done = d0;
    c1_done = d1;
    tick();
    c0_done = 1'b0;
    c1_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_dual = 1'b0; cfg_send_len = 32'd0;
    src_hsk = 1'b0; c0_hsk = 1'b0; c1_hsk = 1'b0; c0_done = 1'b0; c1_done = 1'b0;
    tick(); tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_gate", src_gate, 1'b0);
    check_eq("rst_txd", tx_done, 1'b0);
    check_eq("rst_len0", len_c0, 32'd0);
    rst = 1'b0;
    tick();

    // Dual L=10
    start_tx(32'd10, 1'b1);
    check_eq("t1_busy_load", busy, 1'b1);
    check_eq("t1_gate_load", src_gate, 1'b0);
    tick();
    check_eq("t1_gate_t2", src_gate, 1'b1);
    check_eq("t1_len0", len_c0, 32'd5);
    check_eq("t1_len1", len_c1, 32'd5);
    check_eq("t1_fork", fork_enable, 1'b1);
    run_beats(1'b1, adm);
    check_eq("t1_admitted", adm, 32'd10);
    check_eq("t1_cnt0", cnt_c0, 32'd5);
    check_eq("t1_cnt1", cnt_c1, 32'd5);
    pulse_done(1'b1, 1'b0);
    check_eq("t1_txd_early", tx_done, 1'b0);
    pulse_done(1'b0, 1'b1);
    check_eq("t1_txd_d", tx_done, 1'b0);
    tick();
    check_eq("t1_txd_d1", tx_done, 1'b1);
    check_eq("t1_idle", busy, 1'b0);
    check_eq("t1_timeout", timeout, 1'b0);
    tick();
    check_eq("t1_txd_once", tx_done, 1'b0);

    // Dual L=7, simultaneous done pulses
    start_tx(32'd7, 1'b1);
    tick();
    check_eq("t2_len0", len_c0, 32'd4);
    check_eq("t2_len1", len_c1, 32'd3);
    run_beats(1'b1, adm);
    check_eq("t2_admitted", adm, 32'd7);
    check_eq("t2_cnt0", cnt_c0, 32'd4);
    check_eq("t2_cnt1", cnt_c1, 32'd3);
    pulse_done(1'b1, 1'b1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (tx_done) pulses++;
      tick();
    end
    check_eq("t2_pulses", pulses, 32'd1);
    check_eq("t2_err", err_len, 1'b0);

    // Single L=1: C1 flag pre-set
    start_tx(32'd1, 1'b0);
    tick();
    check_eq("t3_len0", len_c0, 32'd1);
    check_eq("t3_len1", len_c1, 32'd0);
    check_eq("t3_fork", fork_enable, 1'b0);
    run_beats(1'b0, adm);
    check_eq("t3_admitted", adm, 32'd1);
    pulse_done(1'b1, 1'b0);
    check_eq("t3_txd_d", tx_done, 1'b0);
    tick();
    check_eq("t3_txd_d1", tx_done, 1'b1);
    tick();

    // L=0: straight to completion, gate never opens
    start_tx(32'd0, 1'b0);
    check_eq("t3z_gate_t1", src_gate, 1'b0);
    tick();
    check_eq("t3z_gate_t2", src_gate, 1'b0);
    check_eq("t3z_txd_t2", tx_done, 1'b0);
    tick();
    check_eq("t3z_txd_t3", tx_done, 1'b1);
    check_eq("t3z_gate_t3", src_gate, 1'b0);
    check_eq("t3z_len0", len_c0, 32'd0);
    tick();

    // Start during RUN and done in IDLE are ignored
    start_tx(32'd4, 1'b1);
    tick();
    src_hsk = 1'b1; c1_hsk = 1'b1; start = 1'b1; cfg_send_len = 32'd9;
    tick();
    src_hsk = 1'b0; c1_hsk = 1'b0; start = 1'b0;
    check_eq("t4_len0", len_c0, 32'd2);
    check_eq("t4_len1", len_c1, 32'd2);
    run_beats(1'b1, adm);
    check_eq("t4_admitted", adm, 32'd3);
    check_eq("t4_cnt0", cnt_c0, 32'd2);
    check_eq("t4_cnt1", cnt_c1, 32'd2);
    pulse_done(1'b1, 1'b1);
    tick();
    check_eq("t4_txd", tx_done, 1'b1);
    tick();
    pulse_done(1'b1, 1'b0);
    check_eq("t4_idle_done_txd", tx_done, 1'b0);
    check_eq("t4_idle_done_busy", busy, 1'b0);
    tick();
    check_eq("t4_idle_done_txd2", tx_done, 1'b0);
    start_tx(32'd2, 1'b1);
    tick();
    run_beats(1'b1, adm);
    pulse_done(1'b0, 1'b1);
    tick(); tick();
    check_eq("t4_no_stale_f0", tx_done, 1'b0);
    check_eq("t4_still_busy", busy, 1'b1);
    pulse_done(1'b1, 1'b0);
    tick();
    check_eq("t4_txd2", tx_done, 1'b1);
    tick();

    // Overrun on C0, sticky err_len, then reset mid-RUN
    start_tx(32'd5, 1'b0);
    tick();
    run_beats(1'b0, adm);
    check_eq("t5_admitted", adm, 32'd5);
    check_eq("t5_err_pre", err_len, 1'b0);
    c0_hsk = 1'b1;
    tick();
    c0_hsk = 1'b0;
    check_eq("t5_err", err_len, 1'b1);
    check_eq("t5_cnt0", cnt_c0, 32'd6);
    pulse_done(1'b1, 1'b0);
    tick();
    check_eq("t5_txd", tx_done, 1'b1);
    tick();
    check_eq("t5_err_held", err_len, 1'b1);
    start_tx(32'd2, 1'b0);
    check_eq("t5_err_clr", err_len, 1'b0);
    check_eq("t5_cnt_clr", cnt_c0, 32'd0);
    tick();
    check_eq("t5_run", src_gate, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("t5_rst_gate", src_gate, 1'b0);
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_len0", len_c0, 32'd0);
    check_eq("t5_rst_fork", fork_enable, 1'b0);
    check_eq("t5_rst_txd", tx_done, 1'b0);
    rst = 1'b0;
    tick();

`ifdef PAICORE_SEND_SCHED_TIMEOUT_EN
    // Watchdog: C1 done never arrives
    start_tx(32'd2, 1'b1);
    tick();
    run_beats(1'b1, adm);
    pulse_done(1'b1, 1'b0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (tx_done) pulses++;
      tick();
    end
    check_eq("t6_timeout", timeout, 1'b1);
    check_eq("t6_pulses", pulses, 32'd1);
    check_eq("t6_idle", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
